// File: rtl/reg_file_scrub_if.sv
// Core-side bus of the scrubbing register file: two read ports, one write port, ready flag.
interface reg_file_scrub_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            WE3;
  logic [AW-1:0]   A1;
  logic [AW-1:0]   A2;
  logic [AW-1:0]   A3;
  logic [XLEN-1:0] WD3;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic            rf_ready;

  modport master (
    output WE3, A1, A2, A3, WD3,
    input  RD1, RD2, rf_ready
  );

  modport slave (
    input  WE3, A1, A2, A3, WD3,
    output RD1, RD2, rf_ready
  );
endinterface

// File: rtl/reg_file_scrub.sv
// Integer register file (x0 = 0) with async reads, optional write-first bypass,
// and a post-reset scrub that zeroes x1..x(NREG-1) one register per cycle.
module reg_file_scrub #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = $clog2(NREG),
  parameter int unsigned BYPASS = 1
) (
  input logic            clk,
  input logic            rst,
  reg_file_scrub_if.slave bus
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_t          state, state_next;
  logic [AW-1:0]   clr_idx, clr_idx_next;
  logic            rf_ready_q, rf_ready_next;
  logic            clr_we, wr_en;
  logic [XLEN-1:0] regs [NREG];

  // State register; reset restarts the scrub but leaves contents alone
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= CLEAR;
      clr_idx    <= AW'(1);
      rf_ready_q <= 1'b0;
    end else begin
      state      <= state_next;
      clr_idx    <= clr_idx_next;
      rf_ready_q <= rf_ready_next;
    end
  end

  // Next-state: walk clr_idx up to NREG-1, then sit in READY
  always_comb begin
    state_next    = state;
    clr_idx_next  = clr_idx;
    rf_ready_next = rf_ready_q;
    case (state)
      CLEAR: begin
        if (clr_idx == LAST_IDX) begin
          state_next    = READY;
          rf_ready_next = 1'b1;
        end else begin
          clr_idx_next = clr_idx + AW'(1);
        end
      end
      READY: begin
        rf_ready_next = 1'b1;
      end
      default: begin
        state_next    = CLEAR;
        rf_ready_next = 1'b0;
      end
    endcase
  end

  assign clr_we = rst && (state == CLEAR);
  assign wr_en  = rst && (state == READY) && bus.WE3 && (bus.A3 != '0);

  // Storage: scrub writes take priority; architectural writes only once READY
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[clr_idx] <= '0;
    end else if (wr_en) begin
      regs[bus.A3] <= bus.WD3;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    logic [XLEN-1:0] d;
    if (!rst || !rf_ready_q || (a == '0)) begin
      d = '0;
    end else if ((BYPASS != 0) && bus.WE3 && (bus.A3 == a)) begin
      d = bus.WD3;
    end else begin
      d = regs[a];
    end
    return d;
  endfunction

  assign bus.RD1      = read_port(bus.A1);
  assign bus.RD2      = read_port(bus.A2);
  assign bus.rf_ready = rf_ready_q;

endmodule

// File: tb/tb_reg_file_scrub.sv
// Directed bench: a BYPASS=1 and a BYPASS=0 register file driven in lockstep.
module tb_reg_file_scrub;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] mem [32];

  reg_file_scrub_if #(.XLEN(32), .AW(5)) bus_b ();
  reg_file_scrub_if #(.XLEN(32), .AW(5)) bus_n ();

  reg_file_scrub #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );
  reg_file_scrub #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input logic [31:0] wd);
    bus_b.WE3 = we; bus_b.A1 = a1; bus_b.A2 = a2; bus_b.A3 = a3; bus_b.WD3 = wd;
    bus_n.WE3 = we; bus_n.A1 = a1; bus_n.A2 = a2; bus_n.A3 = a3; bus_n.WD3 = wd;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    drive(1'b1, 5'd0, 5'd0, a, d);
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
  endtask

  task automatic rd_both(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2);
    drive(1'b0, a1, a2, 5'd0, 32'h0);
    #1;
    chk({tag, " b.rd1"}, bus_b.RD1, e1);
    chk({tag, " b.rd2"}, bus_b.RD2, e2);
    chk({tag, " n.rd1"}, bus_n.RD1, e1);
    chk({tag, " n.rd2"}, bus_n.RD2, e2);
  endtask

  // Assert reset for n edges; reads must already be zero combinationally
  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    chk("rst rd1 b", bus_b.RD1, 32'h0);
    chk("rst rd1 n", bus_n.RD1, 32'h0);
    repeat (n) @(posedge clk);
    #1;
    chk("rst ready b", 32'(bus_b.rf_ready), 32'h0);
    chk("rst ready n", 32'(bus_n.rf_ready), 32'h0);
    rst = 1'b1;
  endtask

  // Ready must rise exactly at edge 31; optional write attempt during CLEAR edge wr_cycle
  task automatic scrub_check(input string tag, input int wr_cycle);
    for (int e = 1; e <= 31; e++) begin
      @(posedge clk); #1;
      chk({tag, " ready b"}, 32'(bus_b.rf_ready), (e == 31) ? 32'h1 : 32'h0);
      chk({tag, " ready n"}, 32'(bus_n.rf_ready), (e == 31) ? 32'h1 : 32'h0);
      if (e < 31) begin
        chk({tag, " rd1 b"}, bus_b.RD1, 32'h0);
        chk({tag, " rd1 n"}, bus_n.RD1, 32'h0);
      end
      if (wr_cycle > 0 && e == wr_cycle - 1) begin
        bus_b.WE3 = 1'b1; bus_b.A3 = 5'd31; bus_b.WD3 = 32'hFFFF_FFFF;
        bus_n.WE3 = 1'b1; bus_n.A3 = 5'd31; bus_n.WD3 = 32'hFFFF_FFFF;
      end
      if (wr_cycle > 0 && e == wr_cycle) begin
        bus_b.WE3 = 1'b0;
        bus_n.WE3 = 1'b0;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    @(posedge clk); #1;
    do_reset(2);
    scrub_check("init", 0);

    // Fill every register with random data and read it back
    mem[0] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      mem[i] = $urandom;
      wr(5'(i), mem[i]);
    end
    for (int i = 1; i < 32; i++) begin
      rd_both("fill", 5'(i), 5'(32 - i), mem[i], mem[32 - i]);
    end

    // Reset over live data: scrub must zero everything, write in CLEAR dropped
    drive(1'b0, 5'd31, 5'd1, 5'd0, 32'h0);
    do_reset(2);
    scrub_check("scrub", 3);
    for (int i = 0; i < 32; i++) begin
      rd_both("zero", 5'(i), 5'(31 - i), 32'h0, 32'h0);
    end
    rd_both("x31 drop", 5'd31, 5'd31, 32'h0, 32'h0);

    // Basic write/read
    wr(5'd5, 32'hDEAD_BEEF);
    rd_both("basic", 5'd5, 5'd6, 32'hDEAD_BEEF, 32'h0);

    // x0 is hardwired: same-cycle and next-cycle reads stay zero
    drive(1'b1, 5'd0, 5'd0, 5'd0, 32'h1234_5678);
    #1;
    chk("x0 same b", bus_b.RD1, 32'h0);
    chk("x0 same n", bus_n.RD1, 32'h0);
    @(posedge clk); #1;
    rd_both("x0 next", 5'd0, 5'd0, 32'h0, 32'h0);

    // Extreme addresses on both ports
    wr(5'd31, 32'h8000_0001);
    wr(5'd1, 32'h7FFF_FFFE);
    rd_both("edge addr", 5'd31, 5'd1, 32'h8000_0001, 32'h7FFF_FFFE);

    // Bypass vs old-data on a same-cycle write/read of x7
    wr(5'd7, 32'h1);
    drive(1'b1, 5'd7, 5'd7, 5'd7, 32'h2);
    #1;
    chk("byp rd1 b", bus_b.RD1, 32'h2);
    chk("byp rd2 b", bus_b.RD2, 32'h2);
    chk("byp rd1 n", bus_n.RD1, 32'h1);
    chk("byp rd2 n", bus_n.RD2, 32'h1);
    @(posedge clk); #1;
    rd_both("byp next", 5'd7, 5'd7, 32'h2, 32'h2);
    drive(1'b1, 5'd7, 5'd5, 5'd7, 32'h3);
    #1;
    chk("byp split rd1 b", bus_b.RD1, 32'h3);
    chk("byp split rd2 b", bus_b.RD2, 32'hDEAD_BEEF);
    chk("byp split rd1 n", bus_n.RD1, 32'h2);
    chk("byp split rd2 n", bus_n.RD2, 32'hDEAD_BEEF);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0);

    // Mid-operation reset
    wr(5'd10, 32'hA5A5_A5A5);
    rd_both("x10 pre", 5'd10, 5'd10, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    do_reset(1);
    scrub_check("midop", 0);
    rd_both("x10 post", 5'd10, 5'd10, 32'h0, 32'h0);

    // Reset pulsed at scrub cycle 15 restarts a full scrub
    wr(5'd12, 32'h0000_005A);
    drive(1'b0, 5'd12, 5'd12, 5'd0, 32'h0);
    do_reset(1);
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      chk("part ready b", 32'(bus_b.rf_ready), 32'h0);
      chk("part ready n", 32'(bus_n.rf_ready), 32'h0);
    end
    do_reset(1);
    scrub_check("restart", 0);
    rd_both("x12 post", 5'd12, 5'd12, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
